// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: flow-controlled pipeline stage register.
// Carries a control vector, two data words and a destination register
// number between CPU stages with a valid/ready handshake. With SKID=1 a
// second entry absorbs the in-flight beat when out_ready drops, so in_ready
// can be a pure register output. With SKID=0 the stage holds one entry and
// in_ready passes through from out_ready. Bubbles never expose control bits.
module pipe_stage_reg #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 32,
    parameter int RN_W   = 5,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [RN_W-1:0]   in_rn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [RN_W-1:0]   out_rn,
    output logic [1:0]        occupancy
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;

    // Main register: always the oldest entry, drives the outputs.
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_d0;
    logic [DATA_W-1:0]   r_main_d1;
    logic [RN_W-1:0]     r_main_rn;

    // Skid register: the younger entry, only ever filled when SKID=1.
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_d0;
    logic [DATA_W-1:0]   r_skid_d1;
    logic [RN_W-1:0]     r_skid_rn;

    logic                w_out_valid;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_consume;

    assign w_out_valid = (r_state != S_EMPTY);

    // Ready: registered-state-only with the skid buffer, pass-through without.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign w_in_ready = (r_state != S_TWO);
        end else begin : g_pass_ready
            assign w_in_ready = !w_out_valid || out_ready;
        end
    endgenerate

    assign w_accept  = in_valid && w_in_ready;
    assign w_consume = w_out_valid && out_ready;

    // State and storage update; rst beats flush beats the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_main_ctrl <= '0;
            r_main_d0   <= '0;
            r_main_d1   <= '0;
            r_main_rn   <= '0;
            r_skid_ctrl <= '0;
            r_skid_d0   <= '0;
            r_skid_d1   <= '0;
            r_skid_rn   <= '0;
        end else if (flush) begin
            // Data registers keep stale values; the state alone hides them.
            r_state <= S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= S_ONE;
                        r_main_ctrl <= in_ctrl;
                        r_main_d0   <= in_data0;
                        r_main_d1   <= in_data1;
                        r_main_rn   <= in_rn;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_consume) begin
                        // Old entry leaves, new one takes its place.
                        r_main_ctrl <= in_ctrl;
                        r_main_d0   <= in_data0;
                        r_main_d1   <= in_data1;
                        r_main_rn   <= in_rn;
                    end else if (w_accept && (SKID != 0)) begin
                        // Downstream stalled: park the in-flight beat.
                        r_state     <= S_TWO;
                        r_skid_ctrl <= in_ctrl;
                        r_skid_d0   <= in_data0;
                        r_skid_d1   <= in_data1;
                        r_skid_rn   <= in_rn;
                    end else if (w_consume) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_consume) begin
                        r_state     <= S_ONE;
                        r_main_ctrl <= r_skid_ctrl;
                        r_main_d0   <= r_skid_d0;
                        r_main_d1   <= r_skid_d1;
                        r_main_rn   <= r_skid_rn;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    // Bubble gating: a non-valid slot can never carry RegWrite downstream.
    assign out_ctrl  = r_main_ctrl & {CTRL_W{w_out_valid}};
    assign out_data0 = r_main_d0;
    assign out_data1 = r_main_d1;
    assign out_rn    = r_main_rn;
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: drives a SKID=1 and a SKID=0 instance with the
// same inputs and compares both against FIFO-queue reference models.
module tb_pipe_stage_reg;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [4:0]  rn;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [1:0]  in_ctrl;
    logic [31:0] in_data0, in_data1;
    logic [4:0]  in_rn;

    logic        rdy1, ov1, rdy0, ov0;
    logic [1:0]  oc1, oc0, occ1, occ0;
    logic [31:0] oa1, ob1, oa0, ob0;
    logic [4:0]  orn1, orn0;

    int vectors = 0;
    int miscompares = 0;
    ent_t q1[$];
    ent_t q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(2), .DATA_W(32), .RN_W(5), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
        .in_ctrl(in_ctrl), .in_data0(in_data0), .in_data1(in_data1), .in_rn(in_rn),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data0(oa1),
        .out_data1(ob1), .out_rn(orn1), .occupancy(occ1));

    pipe_stage_reg #(.CTRL_W(2), .DATA_W(32), .RN_W(5), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
        .in_ctrl(in_ctrl), .in_data0(in_data0), .in_data1(in_data1), .in_rn(in_rn),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data0(oa0),
        .out_data1(ob0), .out_rn(orn0), .occupancy(occ0));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare both DUTs against the queues, clock once, advance the queues.
    task automatic step();
        ent_t cur;
        bit ev1, er1, ev0, er0;
        #2;
        ev1 = (q1.size() != 0);
        er1 = (q1.size() < 2);
        ev0 = (q0.size() != 0);
        er0 = (q0.size() == 0) || out_ready;
        chk("s1.in_ready", rdy1, er1);
        chk("s1.out_valid", ov1, ev1);
        chk("s1.occupancy", occ1, q1.size());
        if (ev1) begin
            cur = q1[0];
            chk("s1.out_ctrl", oc1, cur.ctrl);
            chk("s1.out_data0", oa1, cur.d0);
            chk("s1.out_data1", ob1, cur.d1);
            chk("s1.out_rn", orn1, cur.rn);
        end else chk("s1.bubble_ctrl", oc1, 0);
        chk("s0.in_ready", rdy0, er0);
        chk("s0.out_valid", ov0, ev0);
        chk("s0.occupancy", occ0, q0.size());
        if (ev0) begin
            cur = q0[0];
            chk("s0.out_ctrl", oc0, cur.ctrl);
            chk("s0.out_data0", oa0, cur.d0);
            chk("s0.out_data1", ob0, cur.d1);
            chk("s0.out_rn", orn0, cur.rn);
        end else chk("s0.bubble_ctrl", oc0, 0);
        cur.ctrl = in_ctrl; cur.d0 = in_data0; cur.d1 = in_data1; cur.rn = in_rn;
        @(posedge clk);
        if (rst || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (ev1 && out_ready) void'(q1.pop_front());
            if (in_valid && er1) q1.push_back(cur);
            if (ev0 && out_ready) void'(q0.pop_front());
            if (in_valid && er0) q0.push_back(cur);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] d1,
                         input logic [4:0] rn, input logic ordy);
        in_valid = v; in_ctrl = c; in_data1 = d1; in_data0 = ~d1; in_rn = rn;
        out_ready = ordy;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ov1"}, ov1, 0);   chk({tag, ".oc1"}, oc1, 0);
        chk({tag, ".oa1"}, oa1, 0);   chk({tag, ".ob1"}, ob1, 0);
        chk({tag, ".orn1"}, orn1, 0); chk({tag, ".occ1"}, occ1, 0);
        chk({tag, ".rdy1"}, rdy1, 1);
        chk({tag, ".ov0"}, ov0, 0);   chk({tag, ".oa0"}, oa0, 0);
        chk({tag, ".orn0"}, orn0, 0); chk({tag, ".occ0"}, occ0, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b1, 2'b11, 32'hDEAD, 5'd7, 1'b0);
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0);
        chk_reset_vals("reset");

        // Streaming at one entry per cycle.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'b01, 32'(i), 5'(i), 1'b1);
            step();
            chk("stream.d1", ob1, i);
            chk("stream.occ", occ1, 1);
        end
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b1);
        step();

        // Back-pressure: two entries absorbed, then drained in order.
        drive(1'b1, 2'b01, 32'hAA, 5'd1, 1'b0); step();
        drive(1'b1, 2'b01, 32'hBB, 5'd2, 1'b0); step();
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0);
        chk("bp.occ", occ1, 2);
        chk("bp.in_ready", rdy1, 0);
        chk("bp.held", ob1, 32'hAA);
        step();
        chk("bp.stable", ob1, 32'hAA);
        out_ready = 1'b1; step();
        chk("bp.second", ob1, 32'hBB);
        chk("bp.ready_back", rdy1, 1);
        step();

        // Flush while full; the live input entry must vanish.
        drive(1'b1, 2'b01, 32'h11, 5'd3, 1'b0); step();
        drive(1'b1, 2'b01, 32'h22, 5'd4, 1'b0); step();
        drive(1'b1, 2'b11, 32'h33, 5'd5, 1'b1); flush = 1'b1; step();
        flush = 1'b0; drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0);
        chk("flush.ov", ov1, 0);
        chk("flush.ctrl", oc1, 0);
        chk("flush.occ", occ1, 0);
        step();

        // Bubble gating after a consume.
        drive(1'b1, 2'b10, 32'h44, 5'd6, 1'b0); step();
        chk("bubble.loaded", oc1, 2'b10);
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b1); step();
        chk("bubble.gated", oc1, 2'b00);

        // SKID=0: stalled entry blocks input, then replace in one cycle.
        drive(1'b1, 2'b01, 32'h55, 5'd8, 1'b0); step();
        drive(1'b1, 2'b01, 32'h66, 5'd9, 1'b0); step();
        chk("s0.blocked", rdy0, 0);
        chk("s0.held", ob0, 32'h55);
        out_ready = 1'b1; step();
        chk("s0.replaced", ob0, 32'h66);
        chk("s0.occ", occ0, 1);
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b1); step();

        // Reset with two entries held.
        drive(1'b1, 2'b11, 32'h77, 5'd10, 1'b0); step();
        drive(1'b1, 2'b11, 32'h88, 5'd11, 1'b0); step();
        chk("midrst.occ_before", occ1, 2);
        rst = 1'b1; step();
        rst = 1'b0; drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0);
        chk_reset_vals("midrst");
        drive(1'b1, 2'b01, 32'h99, 5'd31, 1'b0); step();
        chk("midrst.rn1", orn1, 31);
        chk("midrst.rn0", orn0, 31);
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b1); step();

        // Random traffic against the queue models.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_ctrl   = 2'($urandom);
            in_data0  = $urandom;
            in_data1  = $urandom;
            in_rn     = 5'($urandom);
            flush     = ($urandom_range(31) == 0);
            rst       = ($urandom_range(63) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b1);
        step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
